// File: rtl/procesador_fifo_muestras_mm_to_st_if.sv
// Bus bundle for the host-to-fabric sample FIFO: Avalon-MM write slave
// (register access) plus Avalon-ST source (sample stream).
// Optional macro FIFO_MM_TO_ST_PACKET_EN adds startofpacket/endofpacket.
interface procesador_fifo_muestras_mm_to_st_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            avalonmm_write_slave_address;
  logic                  avalonmm_write_slave_write;
  logic [31:0]           avalonmm_write_slave_writedata;
  logic                  avalonmm_write_slave_read;
  logic [31:0]           avalonmm_write_slave_readdata;
  logic [DATA_WIDTH-1:0] avalonst_source_data;
  logic                  avalonst_source_valid;
  logic                  avalonst_source_ready;
`ifdef FIFO_MM_TO_ST_PACKET_EN
  logic                  avalonst_source_startofpacket;
  logic                  avalonst_source_endofpacket;
`endif

`ifdef FIFO_MM_TO_ST_PACKET_EN
  // FIFO side
  modport slave (
    input  avalonmm_write_slave_address,
    input  avalonmm_write_slave_write,
    input  avalonmm_write_slave_writedata,
    input  avalonmm_write_slave_read,
    output avalonmm_write_slave_readdata,
    output avalonst_source_data,
    output avalonst_source_valid,
    input  avalonst_source_ready,
    output avalonst_source_startofpacket,
    output avalonst_source_endofpacket
  );
  // Host / sink side
  modport master (
    output avalonmm_write_slave_address,
    output avalonmm_write_slave_write,
    output avalonmm_write_slave_writedata,
    output avalonmm_write_slave_read,
    input  avalonmm_write_slave_readdata,
    input  avalonst_source_data,
    input  avalonst_source_valid,
    output avalonst_source_ready,
    input  avalonst_source_startofpacket,
    input  avalonst_source_endofpacket
  );
`else
  // FIFO side
  modport slave (
    input  avalonmm_write_slave_address,
    input  avalonmm_write_slave_write,
    input  avalonmm_write_slave_writedata,
    input  avalonmm_write_slave_read,
    output avalonmm_write_slave_readdata,
    output avalonst_source_data,
    output avalonst_source_valid,
    input  avalonst_source_ready
  );
  // Host / sink side
  modport master (
    output avalonmm_write_slave_address,
    output avalonmm_write_slave_write,
    output avalonmm_write_slave_writedata,
    output avalonmm_write_slave_read,
    input  avalonmm_write_slave_readdata,
    input  avalonst_source_data,
    input  avalonst_source_valid,
    output avalonst_source_ready
  );
`endif
endinterface

// File: rtl/procesador_fifo_muestras_mm_to_st.sv
// Host-to-fabric sample FIFO. The processor pushes words through the MM
// slave (DATA/CONTROL/STATUS/FLUSH registers); words are buffered in a
// DEPTH-word RAM, prefetched into one output register and replayed on the
// ST source with valid/ready backpressure.
// Optional macro FIFO_MM_TO_ST_PACKET_EN: sop/eop framing with a
// programmable packet length in CONTROL[31:16].
module procesador_fifo_muestras_mm_to_st #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                                   clock,
  input  logic                                   reset,
  procesador_fifo_muestras_mm_to_st_if.slave     bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int          CNT_W = DEPTH_LOG2 + 1;
  localparam int          LVL_W = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_CONTROL = 2'd1,
    REG_STATUS  = 2'd2,
    REG_FLUSH   = 2'd3
  } reg_addr_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      ram_count_q, ram_count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_full_q, out_full_d;
  logic                  enable_q, enable_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           readdata_q, readdata_d;

  reg_addr_e             addr;
  logic                  wr_data, wr_ctrl, wr_status, wr_flush;
  logic                  fifo_full, push, xfer, prefetch, src_valid;
  logic [LVL_W-1:0]      level;
  logic [31:0]           status_word;
  logic [15:0]           ctrl_upper;

`ifdef FIFO_MM_TO_ST_PACKET_EN
  logic [15:0]           pkt_len_q, pkt_len_d;
  logic [15:0]           cur_len_q, cur_len_d;
  logic [15:0]           beat_q, beat_d;
  logic [15:0]           eff_len;
  logic [15:0]           last_beat;
  logic                  eop_hit;
`endif

  // Register decode, handshake and prefetch qualification
  always_comb begin
    addr      = reg_addr_e'(bus.avalonmm_write_slave_address);
    wr_data   = bus.avalonmm_write_slave_write && (addr == REG_DATA);
    wr_ctrl   = bus.avalonmm_write_slave_write && (addr == REG_CONTROL);
    wr_status = bus.avalonmm_write_slave_write && (addr == REG_STATUS);
    wr_flush  = bus.avalonmm_write_slave_write && (addr == REG_FLUSH);
    fifo_full = (ram_count_q == CNT_W'(DEPTH));
    push      = wr_data && !fifo_full;
    src_valid = out_full_q && enable_q;
    xfer      = src_valid && bus.avalonst_source_ready;
    // Refill the output register when it is empty or being drained now
    prefetch  = enable_q && (ram_count_q != '0) && (!out_full_q || xfer);
    level     = LVL_W'(ram_count_q) + LVL_W'(out_full_q);
  end

`ifdef FIFO_MM_TO_ST_PACKET_EN
  // Packet framing: length is latched on the sop beat so CONTROL writes
  // mid-packet only affect the following packet
  always_comb begin
    eff_len   = (beat_q == '0) ? pkt_len_q : cur_len_q;
    last_beat = (eff_len == '0) ? '0 : eff_len - 16'd1;
    eop_hit   = (beat_q == last_beat);
    pkt_len_d = pkt_len_q;
    cur_len_d = cur_len_q;
    beat_d    = beat_q;
    if (xfer) begin
      if (beat_q == '0) cur_len_d = pkt_len_q;
      beat_d = eop_hit ? '0 : beat_q + 16'd1;
    end
    if (wr_ctrl)  pkt_len_d = bus.avalonmm_write_slave_writedata[31:16];
    if (wr_flush) beat_d = '0;
    ctrl_upper = pkt_len_q;
  end
`else
  // No framing: CONTROL upper half reads as zero
  always_comb begin
    ctrl_upper = '0;
  end
`endif

  // Next-state for pointers, occupancy, output register and control bits
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    out_data_d  = out_data_q;
    out_full_d  = out_full_q;
    enable_d    = enable_q;
    overflow_d  = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);

    if (prefetch) begin
      rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(1);
      out_data_d = mem[rd_ptr_q];
      out_full_d = 1'b1;
    end else if (xfer) begin
      out_full_d = 1'b0;
    end

    case ({push, prefetch})
      2'b10:   ram_count_d = ram_count_q + CNT_W'(1);
      2'b01:   ram_count_d = ram_count_q - CNT_W'(1);
      default: ram_count_d = ram_count_q;
    endcase

    if (wr_data && fifo_full) overflow_d = 1'b1;
    if (wr_status)            overflow_d = 1'b0;
    if (wr_ctrl)              enable_d   = bus.avalonmm_write_slave_writedata[0];

    // Flush overrides any push/prefetch bookkeeping of the same cycle
    if (wr_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      out_full_d  = 1'b0;
    end
  end

  // Register read mux; samples state of the request cycle
  always_comb begin
    status_word = {13'd0, overflow_q, fifo_full, (level == '0), 16'(level)};
    readdata_d  = readdata_q;
    if (bus.avalonmm_write_slave_read) begin
      case (addr)
        REG_CONTROL: readdata_d = {ctrl_upper, 15'd0, enable_q};
        REG_STATUS:  readdata_d = status_word;
        default:     readdata_d = '0;
      endcase
    end
  end

  // Sample RAM write port (no reset on storage)
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= DATA_WIDTH'(bus.avalonmm_write_slave_writedata);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      readdata_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
      enable_q    <= enable_d;
      overflow_q  <= overflow_d;
      readdata_q  <= readdata_d;
    end
  end

`ifdef FIFO_MM_TO_ST_PACKET_EN
  // Packet framing registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_len_q <= '0;
      cur_len_q <= '0;
      beat_q    <= '0;
    end else begin
      pkt_len_q <= pkt_len_d;
      cur_len_q <= cur_len_d;
      beat_q    <= beat_d;
    end
  end

  assign bus.avalonst_source_startofpacket = src_valid && (beat_q == '0);
  assign bus.avalonst_source_endofpacket   = src_valid && eop_hit;
`endif

  assign bus.avalonst_source_valid         = src_valid;
  assign bus.avalonst_source_data          = out_data_q;
  assign bus.avalonmm_write_slave_readdata = readdata_q;

endmodule

// File: doc/procesador_fifo_muestras_mm_to_st.md
Name: procesador_fifo_muestras_mm_to_st

Overview:
- Host-to-fabric sample FIFO: the processor writes 32-bit words through an Avalon-MM write slave; the block buffers them and replays them on an Avalon-ST source with valid/ready backpressure.
- Feeds the signal-processing pipeline with samples and coefficients.
- Provides control/status registers: enable, flush, level, overflow.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and of ST data.
- DEPTH_LOG2, 9, log2 of RAM depth (DEPTH = 512 words).

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- avalonmm_write_slave_address  in  2  register select
- avalonmm_write_slave_write  in  1  MM write strobe
- avalonmm_write_slave_writedata  in  32  MM write data
- avalonmm_write_slave_read  in  1  MM read strobe
- avalonmm_write_slave_readdata  out  32  MM read data; read latency 1, no waitrequest
- avalonst_source_data  out  DATA_WIDTH  stream data
- avalonst_source_valid  out  1  stream valid
- avalonst_source_ready  in  1  stream ready; ready latency 0

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Register map (word addresses):
  - 0 DATA (W): push. Reads return 0.
  - 1 CONTROL (R/W): bit0 enable. Other bits read 0.
  - 2 STATUS (R): [15:0] level, bit16 empty, bit17 full, bit18 overflow. Any write clears overflow.
  - 3 FLUSH (W): any write flushes. Reads return 0.
- Storage and level:
  - DEPTH-word RAM with wr_ptr and rd_ptr (DEPTH_LOG2 bits, natural wrap) plus ram_count (DEPTH_LOG2+1 bits).
  - One output register holds out_data and out_full.
  - level = ram_count + out_full. empty = (level == 0). full = (ram_count == DEPTH).
- Push:
  - Write to address 0 with full = 0: word stored at wr_ptr, wr_ptr increments.
  - Write to address 0 with full = 1: word dropped, overflow set (sticky), pointers unchanged.
- Prefetch:
  - Condition: enable = 1 and ram_count > 0 and (out_full = 0 or transfer this cycle).
  - Action: RAM word moves into the output register; rd_ptr increments.
  - Push and prefetch in the same cycle: ram_count unchanged.
- Source handshake:
  - avalonst_source_valid = out_full & enable.
  - Transfer occurs when valid & ready. On transfer without refill, out_full clears.
  - Data is held stable while valid = 1 and ready = 0.
- Latency: a push at cycle N into a fully empty, enabled FIFO gives valid = 1 at cycle N+2. Streaming sustains 1 word per cycle with ready held high.
- enable = 0:
  - Valid forced low and prefetch stops.
  - The output register keeps its word, and that word is presented first when enable returns to 1.
  - Pushes are still accepted.
- Flush (write to address 3), takes effect in one cycle:
  - wr_ptr, rd_ptr and ram_count go to 0; out_full goes to 0.
  - overflow and enable are unchanged.
  - A transfer in the flush cycle still completes on the ST side; no state survives it.
- Read data: readdata is registered and valid the cycle after a read. Status reflects state at the read-request cycle.
- Reset: the following all go to 0:
  - pointers, ram_count, out_full
  - avalonst_source_valid, avalonst_source_data
  - avalonmm_write_slave_readdata
  - enable, overflow
- Reset mid-stream discards all contents.
- Simultaneous read and write on MM: both are served (read of pre-write state).

Optional Feature:
- Macro: FIFO_MM_TO_ST_PACKET_EN.
- Defined:
  - Adds outputs avalonst_source_startofpacket and avalonst_source_endofpacket (1 bit each).
  - Address 1 bits [31:16] become pkt_len (reset 0; 0 means 1).
  - A beat counter runs over transfers. sop is asserted on beat 0; eop is asserted on beat pkt_len-1, then the counter wraps to 0.
  - Flush and reset clear the counter. Writing CONTROL mid-packet takes effect at the next sop.
- Not defined: no sop/eop ports, no counter, CONTROL bits [31:16] read 0.

Test Plan:
- Reset, write CONTROL=1, push 0xA5A5_0001 at cycle N, ready=1 -> valid=1 at N+2 with data 0xA5A5_0001; STATUS then reads level=0, empty=1.
- enable=0, push 512 words 0..511, push 0xDEAD -> STATUS full=1, overflow=1, level=512. Enable with ready=1 -> 512 consecutive beats 0..511, 0xDEAD never appears. Write STATUS -> overflow=0.
- Streaming with ready toggling 1,0,0,1 and concurrent pushes -> data held during stalls, order preserved, level matches pushes minus transfers every cycle.
- Push 10 words, ready=0, write FLUSH -> next cycle valid=0, level=0. Push 0x55 -> 0x55 is the next word out.
- Assert reset mid-stream with level=7 -> valid=0, readdata=0, level=0, enable=0 the cycle after reset.
- FIFO_MM_TO_ST_PACKET_EN with pkt_len=4 and 8 words -> sop on beats 0 and 4, eop on beats 3 and 7.
